// File: rtl/cnn_layer_1_if.sv
// Stream interface for cnn_layer_1: one pixel in per clock, pooled samples out with a strobe.
interface cnn_layer_1_if;
   logic signed [8:0] pxl_in;
   logic signed [8:0] pool_out;
   logic              valid;

   // Producer/consumer side: drives pixels, observes pooled results.
   modport master (output pxl_in, input pool_out, input valid);
   // Layer side: consumes pixels, produces pooled results.
   modport slave  (input pxl_in, output pool_out, output valid);
endinterface

// File: rtl/cnn_layer_1.sv
// cnn_layer_1: streamed KxK valid convolution followed by 2x2 stride-2 max pooling.
// Pipeline: pixel edge -> window register, +1 edge -> conv_q, +2 edges -> pool_out/valid.
module cnn_layer_1 #(
   parameter int               DIM    = 32,
   parameter int               K      = 5,
   parameter logic [8*K*K-1:0] KERNEL = {{(K*K/2){8'h00}}, 8'h01, {(K*K/2){8'h00}}},
   parameter int               SHIFT  = 0
) (
   input  logic         clk,
   input  logic         reset,
   cnn_layer_1_if.slave bus
);
   localparam int   CW      = $clog2(DIM);
   localparam int   AW      = 24;
   localparam int   PW      = (DIM - K + 1) / 2;
   localparam logic KM1_ODD = 1'((K - 1) % 2);
   localparam logic signed [AW-1:0] SAT_HI = AW'(255);
   localparam logic signed [AW-1:0] SAT_LO = -AW'(256);

   // Weight k of the packed kernel, k = K*row + col.
   function automatic logic signed [7:0] weight(input int k);
      return KERNEL[8*k +: 8];
   endfunction

   // Clamp a wide sum into the signed 9-bit output range.
   function automatic logic signed [8:0] sat9(input logic signed [AW-1:0] v);
      if (v > SAT_HI) begin
         return 9'sd255;
      end else if (v < SAT_LO) begin
         return -9'sd256;
      end else begin
         return v[8:0];
      end
   endfunction

   // Signed maximum of two samples.
   function automatic logic signed [8:0] smax(input logic signed [8:0] a, input logic signed [8:0] b);
      if (a > b) begin
         return a;
      end else begin
         return b;
      end
   endfunction

   logic [CW-1:0]     col_q, row_q;
   logic signed [8:0] lb_q  [K-1][DIM];  // lb_q[j] holds row (current - 1 - j)
   logic signed [8:0] win_q [K][K];      // win_q[0][0] = oldest row, leftmost column
   logic              win_vld_q, win_rodd_q;
   logic [CW-1:0]     win_c_q;
   logic signed [8:0] conv_q, conv_prev_q;
   logic              conv_vld_q, conv_rodd_q;
   logic [CW-1:0]     conv_c_q;
   logic signed [8:0] pbuf_q [PW];
   logic signed [8:0] pool_q;
   logic              valid_q;

   logic signed [8:0]    col_s [K];
   logic signed [AW-1:0] acc_s;

   // New window column: stored pixels of this column from older rows plus the incoming pixel.
   always_comb begin
      col_s[K-1] = bus.pxl_in;
      for (int kr = 0; kr < K-1; kr++) begin
         col_s[kr] = lb_q[K-2-kr][col_q];
      end
   end

   // Multiply-accumulate over the current window.
   always_comb begin
      acc_s = '0;
      for (int kr = 0; kr < K; kr++) begin
         for (int kc = 0; kc < K; kc++) begin
            acc_s = acc_s + AW'(weight(K*kr + kc)) * AW'(win_q[kr][kc]);
         end
      end
   end

   // Raster counters, line buffers and the sliding window.
   always_ff @(posedge clk) begin
      if (reset) begin
         col_q      <= '0;
         row_q      <= '0;
         win_vld_q  <= 1'b0;
         win_rodd_q <= 1'b0;
         win_c_q    <= '0;
         for (int j = 0; j < K-1; j++) begin
            for (int c = 0; c < DIM; c++) begin
               lb_q[j][c] <= '0;
            end
         end
         for (int kr = 0; kr < K; kr++) begin
            for (int kc = 0; kc < K; kc++) begin
               win_q[kr][kc] <= '0;
            end
         end
      end else begin
         if (col_q == CW'(DIM-1)) begin
            col_q <= '0;
            row_q <= (row_q == CW'(DIM-1)) ? '0 : row_q + 1'b1;
         end else begin
            col_q <= col_q + 1'b1;
         end
         lb_q[0][col_q] <= bus.pxl_in;
         for (int j = 1; j < K-1; j++) begin
            lb_q[j][col_q] <= lb_q[j-1][col_q];
         end
         for (int kr = 0; kr < K; kr++) begin
            for (int kc = 0; kc < K-1; kc++) begin
               win_q[kr][kc] <= win_q[kr][kc+1];
            end
            win_q[kr][K-1] <= col_s[kr];
         end
         // The window is usable only when it neither wraps a row nor reaches above row 0.
         win_vld_q  <= (row_q >= CW'(K-1)) && (col_q >= CW'(K-1));
         win_rodd_q <= row_q[0] ^ KM1_ODD;
         win_c_q    <= col_q - CW'(K-1);
      end
   end

   // Convolution result register, tagged with its output row parity and column.
   always_ff @(posedge clk) begin
      if (reset) begin
         conv_q      <= '0;
         conv_vld_q  <= 1'b0;
         conv_rodd_q <= 1'b0;
         conv_c_q    <= '0;
      end else begin
         conv_q      <= sat9(acc_s >>> SHIFT);
         conv_vld_q  <= win_vld_q;
         conv_rodd_q <= win_rodd_q;
         conv_c_q    <= win_c_q;
      end
   end

   // 2x2 max pooling: even rows fill the pair buffer, odd rows emit the pooled sample.
   always_ff @(posedge clk) begin
      if (reset) begin
         conv_prev_q <= '0;
         pool_q      <= '0;
         valid_q     <= 1'b0;
         for (int p = 0; p < PW; p++) begin
            pbuf_q[p] <= '0;
         end
      end else begin
         valid_q <= 1'b0;
         if (conv_vld_q) begin
            conv_prev_q <= conv_q;
            if (conv_c_q[0]) begin
               if (conv_rodd_q) begin
                  pool_q  <= smax(pbuf_q[conv_c_q[CW-1:1]], smax(conv_prev_q, conv_q));
                  valid_q <= 1'b1;
               end else begin
                  pbuf_q[conv_c_q[CW-1:1]] <= smax(conv_prev_q, conv_q);
               end
            end else begin
               pool_q <= pool_q;
            end
         end else begin
            conv_prev_q <= conv_prev_q;
         end
      end
   end

   assign bus.pool_out = pool_q;
   assign bus.valid    = valid_q;
endmodule

// File: tb/tb_cnn_layer_1.sv
// Testbench for cnn_layer_1: three instances (centre-tap, all +1, all -1 kernels) share one
// pixel stream; observed pulses are compared against a frame-level convolution/pooling model.
module tb_cnn_layer_1;
   localparam int DIM = 32;
   localparam int SHIFT = 0;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   cnn_layer_1_if bus0();
   cnn_layer_1_if bus1();
   cnn_layer_1_if bus2();

   cnn_layer_1 u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
   cnn_layer_1 #(.KERNEL({25{8'h01}})) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
   cnn_layer_1 #(.KERNEL({25{8'hFF}})) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

   int img [DIM][DIM];
   int wts [3][25];
   int obs_cyc [3][$];
   int obs_val [3][$];
   int exp_cyc [3][$];
   int exp_val [3][$];
   int n_edge;
   int checks = 0;
   int passes = 0;

   task automatic clear_queues();
      for (int d = 0; d < 3; d++) begin
         obs_cyc[d].delete(); obs_val[d].delete();
         exp_cyc[d].delete(); exp_val[d].delete();
      end
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      n_edge = 0;
      clear_queues();
   endtask

   task automatic drive_pixel(input int v);
      logic signed [8:0] p;
      p = {1'b0, 8'(v)};
      bus0.pxl_in = p; bus1.pxl_in = p; bus2.pxl_in = p;
      @(posedge clk);
      #1;
      if (bus0.valid === 1'b1) begin obs_cyc[0].push_back(n_edge); obs_val[0].push_back(int'(bus0.pool_out)); end
      if (bus1.valid === 1'b1) begin obs_cyc[1].push_back(n_edge); obs_val[1].push_back(int'(bus1.pool_out)); end
      if (bus2.valid === 1'b1) begin obs_cyc[2].push_back(n_edge); obs_val[2].push_back(int'(bus2.pool_out)); end
      n_edge++;
   endtask

   task automatic stream_frame();
      for (int r = 0; r < DIM; r++)
         for (int c = 0; c < DIM; c++)
            drive_pixel(img[r][c]);
   endtask

   task automatic flush();
      repeat (2) drive_pixel(0);
   endtask

   // Reference: saturated valid convolution at output position (r,c).
   function automatic int conv_at(input int d, input int r, input int c);
      int s = 0;
      for (int kr = 0; kr < 5; kr++)
         for (int kc = 0; kc < 5; kc++)
            s += wts[d][5*kr + kc] * img[r+kr][c+kc];
      s = s >>> SHIFT;
      if (s > 255) s = 255;
      if (s < -256) s = -256;
      return s;
   endfunction

   // Reference: all 196 pooled samples of the current image, with the edge they should appear on.
   task automatic build_expected(input int base);
      for (int d = 0; d < 3; d++)
         for (int i = 0; i < 14; i++)
            for (int j = 0; j < 14; j++) begin
               int m = -100000;
               for (int a = 0; a < 2; a++)
                  for (int b = 0; b < 2; b++)
                     if (conv_at(d, 2*i+a, 2*j+b) > m) m = conv_at(d, 2*i+a, 2*j+b);
               exp_cyc[d].push_back(base + (2*i+5)*DIM + (2*j+5) + 2);
               exp_val[d].push_back(m);
            end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus0.valid !== 1'b0 || bus0.pool_out !== 9'sd0 || bus1.valid !== 1'b0 || bus2.valid !== 1'b0)
         $display("FAIL reset_state: valid %b/%b/%b pool_out %0d, want 0/0/0 and 0", bus0.valid, bus1.valid, bus2.valid, bus0.pool_out);
      else passes++;
   endtask

   task automatic test_ramp(input string tag);
      for (int k = 0; k < DIM*DIM; k++) img[k/DIM][k%DIM] = (k + 1) % 256;
      apply_reset();
      stream_frame();
      flush();
      build_expected(0);
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (obs_cyc[d].size() !== exp_cyc[d].size())
            $display("FAIL %s_count dut%0d: got %0d pulses, want %0d", tag, d, obs_cyc[d].size(), exp_cyc[d].size());
         else passes++;
         for (int n = 0; n < exp_cyc[d].size() && n < obs_cyc[d].size(); n++) begin
            checks++;
            if (obs_cyc[d][n] !== exp_cyc[d][n] || obs_val[d][n] !== exp_val[d][n])
               $display("FAIL %s_pulse dut%0d #%0d: got cycle %0d value %0d, want cycle %0d value %0d", tag, d, n, obs_cyc[d][n], obs_val[d][n], exp_cyc[d][n], exp_val[d][n]);
            else passes++;
         end
      end
      checks++;
      if (obs_cyc[0].size() < 43) begin
         $display("FAIL %s_landmarks: only %0d pulses, want at least 43", tag, obs_cyc[0].size());
      end else if (obs_cyc[0][0] !== 167 || obs_val[0][0] !== 100 || obs_val[0][1] !== 102 ||
                   obs_val[0][14] !== 164 || obs_val[0][42] !== 36) begin
         $display("FAIL %s_landmarks: got first cycle %0d vals %0d %0d %0d %0d, want 167 vals 100 102 164 36", tag,
                  obs_cyc[0][0], obs_val[0][0], obs_val[0][1], obs_val[0][14], obs_val[0][42]);
      end else passes++;
   endtask

   task automatic test_back_to_back();
      for (int r = 0; r < DIM; r++)
         for (int c = 0; c < DIM; c++)
            img[r][c] = $urandom_range(0, 255);
      apply_reset();
      stream_frame();
      stream_frame();
      flush();
      build_expected(0);
      build_expected(DIM*DIM);
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (obs_cyc[d].size() !== exp_cyc[d].size())
            $display("FAIL b2b_count dut%0d: got %0d pulses, want %0d", d, obs_cyc[d].size(), exp_cyc[d].size());
         else passes++;
         for (int n = 0; n < exp_cyc[d].size() && n < obs_cyc[d].size(); n++) begin
            checks++;
            if (obs_cyc[d][n] !== exp_cyc[d][n] || obs_val[d][n] !== exp_val[d][n])
               $display("FAIL b2b_pulse dut%0d #%0d: got cycle %0d value %0d, want cycle %0d value %0d", d, n, obs_cyc[d][n], obs_val[d][n], exp_cyc[d][n], exp_val[d][n]);
            else passes++;
         end
      end
      for (int f = 0; f < 2; f++) begin
         int cnt = 0;
         foreach (obs_cyc[0][n])
            if (obs_cyc[0][n] >= f*DIM*DIM + 167 && obs_cyc[0][n] <= f*DIM*DIM + 1025) cnt++;
         checks++;
         if (cnt !== 196) $display("FAIL b2b_frame_pulses frame%0d: got %0d, want 196", f, cnt);
         else passes++;
      end
   endtask

   task automatic test_saturation();
      int px [3]    = '{200, 10, 20};
      int want1 [3] = '{255, 250, 255};
      int want2 [3] = '{-256, -250, -256};
      for (int s = 0; s < 3; s++) begin
         for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
               img[r][c] = px[s];
         apply_reset();
         stream_frame();
         flush();
         build_expected(0);
         for (int d = 1; d < 3; d++) begin
            checks++;
            if (obs_cyc[d].size() !== exp_cyc[d].size())
               $display("FAIL sat_count px%0d dut%0d: got %0d pulses, want %0d", px[s], d, obs_cyc[d].size(), exp_cyc[d].size());
            else passes++;
            for (int n = 0; n < exp_cyc[d].size() && n < obs_cyc[d].size(); n++) begin
               checks++;
               if (obs_cyc[d][n] !== exp_cyc[d][n] || obs_val[d][n] !== exp_val[d][n])
                  $display("FAIL sat_pulse px%0d dut%0d #%0d: got cycle %0d value %0d, want cycle %0d value %0d", px[s], d, n, obs_cyc[d][n], obs_val[d][n], exp_cyc[d][n], exp_val[d][n]);
               else passes++;
            end
         end
         checks++;
         if (obs_val[1].size() == 0 || obs_val[2].size() == 0)
            $display("FAIL sat_value px%0d: no pulses observed, want %0d and %0d", px[s], want1[s], want2[s]);
         else if (obs_val[1][0] !== want1[s] || obs_val[2][0] !== want2[s])
            $display("FAIL sat_value px%0d: got %0d and %0d, want %0d and %0d", px[s], obs_val[1][0], obs_val[2][0], want1[s], want2[s]);
         else passes++;
      end
   endtask

   task automatic test_midframe_reset();
      for (int k = 0; k < DIM*DIM; k++) img[k/DIM][k%DIM] = (k + 1) % 256;
      apply_reset();
      for (int k = 0; k < 500; k++) drive_pixel(img[k/DIM][k%DIM]);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (bus0.valid !== 1'b0 || bus0.pool_out !== 9'sd0 || bus1.pool_out !== 9'sd0 || bus2.pool_out !== 9'sd0)
         $display("FAIL midframe_reset: valid %b pool_out %0d/%0d/%0d, want 0 and 0/0/0", bus0.valid, bus0.pool_out, bus1.pool_out, bus2.pool_out);
      else passes++;
      test_ramp("restart");
   endtask

   task automatic test_impulse();
      int nz = 0;
      for (int r = 0; r < DIM; r++)
         for (int c = 0; c < DIM; c++)
            img[r][c] = 0;
      img[10][10] = 255;
      apply_reset();
      stream_frame();
      flush();
      build_expected(0);
      checks++;
      if (obs_cyc[0].size() !== exp_cyc[0].size())
         $display("FAIL impulse_count: got %0d pulses, want %0d", obs_cyc[0].size(), exp_cyc[0].size());
      else passes++;
      for (int n = 0; n < exp_cyc[0].size() && n < obs_cyc[0].size(); n++) begin
         checks++;
         if (obs_cyc[0][n] !== exp_cyc[0][n] || obs_val[0][n] !== exp_val[0][n])
            $display("FAIL impulse_pulse #%0d: got cycle %0d value %0d, want cycle %0d value %0d", n, obs_cyc[0][n], obs_val[0][n], exp_cyc[0][n], exp_val[0][n]);
         else passes++;
         if (obs_val[0][n] != 0) nz++;
      end
      checks++;
      if (obs_val[0].size() < 61 || obs_val[0][60] !== 255 || nz !== 1)
         $display("FAIL impulse_only_4_4: got %0d nonzero outputs, want exactly pool(4,4)=255", nz);
      else passes++;
   endtask

   initial begin
      bus0.pxl_in = 9'sd0; bus1.pxl_in = 9'sd0; bus2.pxl_in = 9'sd0;
      for (int k = 0; k < 25; k++) begin
         wts[0][k] = (k == 12) ? 1 : 0;
         wts[1][k] = 1;
         wts[2][k] = -1;
      end
      test_reset();
      test_ramp("ramp");
      test_back_to_back();
      test_saturation();
      test_midframe_reset();
      test_impulse();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
